// File: rtl/sort_pkg.sv
// Shared constants and types for the sorting-network receive path.
package sort_pkg;

    localparam int SORT_WIDTH       = 16;
    localparam int SORT_LANES       = 5;
    localparam int SORT_NET_LATENCY = 6;

    typedef logic [SORT_WIDTH-1:0] word_t;

    function automatic int lane_idx_w();
        return $clog2(SORT_LANES);
    endfunction

endpackage

// File: rtl/sort_drain_if.sv
// Word-serial output stream of the drain: valid/ready handshake plus lane tag.
interface sort_drain_if
    import sort_pkg::*;
#(
    parameter int WIDTH = SORT_WIDTH,
    parameter int LANES = SORT_LANES
);
    localparam int IW = $clog2(LANES);

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [IW-1:0]    out_index;
    logic             out_last;

    modport master (output out_valid, output out_data, output out_index, output out_last,
                    input  out_ready);
    modport slave  (input  out_valid, input  out_data, input  out_index, input  out_last,
                    output out_ready);
endinterface

// File: rtl/vec_fifo.sv
// Register FIFO of whole vectors; the caller decides when push/pop are legal.
module vec_fifo #(
    parameter int W     = 80,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Storage carries no reset; only pointers and count define content.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb head = mem[rd_ptr];

endmodule

// File: rtl/sort_drain.sv
// Captures sorted vectors from the network, buffers them and streams them out
// one word per beat, lane 0 (largest) first, with order and overflow flags.
module sort_drain
    import sort_pkg::*;
#(
    parameter int WIDTH = SORT_WIDTH,
    parameter int LANES = SORT_LANES,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       vec_valid,
    input  logic [LANES*WIDTH-1:0]     vec_in,
    sort_drain_if.master               out,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    input  logic                       clr_flags,
    output logic                       order_err,
    output logic                       overflow
);
    localparam int IW = $clog2(LANES);
    localparam int CW = $clog2(DEPTH+1);
    localparam int VW = LANES*WIDTH;

    logic [IW-1:0] lane;
    logic [VW-1:0] head;
    logic          last, fire, pop, full, push, drop, unsorted;

    always_comb begin
        last           = (lane == IW'(LANES-1));
        out.out_valid  = (fifo_count != '0);
        fire           = out.out_valid & out.out_ready;
        pop            = fire & last;
        full           = (fifo_count == CW'(DEPTH));
        // A pop in the same cycle frees the slot the incoming vector needs.
        push           = vec_valid & (~full | pop);
        drop           = vec_valid & full & ~pop;
        out.out_index  = lane;
        out.out_last   = out.out_valid & last;
        out.out_data   = head[lane*WIDTH +: WIDTH];
    end

    always_comb begin
        unsorted = 1'b0;
        for (int unsigned i = 0; i < LANES-1; i++) begin
            if (vec_in[i*WIDTH +: WIDTH] < vec_in[(i+1)*WIDTH +: WIDTH]) unsorted = 1'b1;
        end
    end

    vec_fifo #(.W(VW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (vec_in),
        .head  (head),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)    lane <= '0;
        else if (fire) lane <= last ? '0 : lane + 1'b1;
    end

    // Set events take priority over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            order_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (push & unsorted) order_err <= 1'b1;
            else if (clr_flags)  order_err <= 1'b0;
            if (drop)            overflow  <= 1'b1;
            else if (clr_flags)  overflow  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sort_drain.sv
// Self-checking bench for sort_drain against a queue-based vector model.
module tb_sort_drain;
    localparam int W = 16;
    localparam int L = 5;
    localparam int D = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           vec_valid;
    logic [L*W-1:0] vec_in;
    logic           clr_flags;
    logic [1:0]     fifo_count;
    logic           order_err;
    logic           overflow;

    sort_drain_if #(.WIDTH(W), .LANES(L)) bus ();

    sort_drain #(.WIDTH(W), .LANES(L), .DEPTH(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vec_valid  (vec_valid),
        .vec_in     (vec_in),
        .out        (bus),
        .fifo_count (fifo_count),
        .clr_flags  (clr_flags),
        .order_err  (order_err),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [L*W-1:0] mq[$];
    int             mlane;
    bit             merr, movf;
    logic [W-1:0]   got[$];

    function automatic logic [W-1:0] wd(input logic [L*W-1:0] v, input int i);
        return v[i*W +: W];
    endfunction

    function automatic logic [L*W-1:0] vec5(input logic [W-1:0] a, b, c, d, e);
        return {e, d, c, b, a};
    endfunction

    function automatic void model_edge(input logic vv, input logic [L*W-1:0] v,
                                       input logic rdy, input logic clr);
        bit fire, pop, push, drop, bad;
        if (!rst_n) begin
            mq.delete(); mlane = 0; merr = 0; movf = 0;
            return;
        end
        fire = (mq.size() != 0) && rdy;
        pop  = fire && (mlane == L-1);
        push = vv && ((mq.size() < D) || pop);
        drop = vv && !push;
        bad  = 0;
        for (int i = 0; i < L-1; i++) if (wd(v, i) < wd(v, i+1)) bad = 1;
        if (clr) begin merr = 0; movf = 0; end
        if (push && bad) merr = 1;
        if (drop) movf = 1;
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(v);
        if (fire) mlane = pop ? 0 : mlane + 1;
    endfunction

    // One clock: drive, compare registered outputs at the falling edge, advance model.
    task automatic cycle(input logic vv, input logic [L*W-1:0] v, input logic rdy, input logic clr);
        bit ev;
        vec_valid = vv; vec_in = v; bus.out_ready = rdy; clr_flags = clr;
        @(negedge clk);
        ev = (mq.size() != 0);
        n_cmp++;
        if (bus.out_valid !== ev) begin
            n_bad++; $display("FAIL out_valid: got %b exp %b t=%0t", bus.out_valid, ev, $time);
        end
        n_cmp++;
        if (bus.out_index !== 3'(mlane)) begin
            n_bad++; $display("FAIL out_index: got %0d exp %0d t=%0t", bus.out_index, mlane, $time);
        end
        n_cmp++;
        if (bus.out_last !== (ev && mlane == L-1)) begin
            n_bad++; $display("FAIL out_last: got %b exp %b t=%0t", bus.out_last, ev && mlane == L-1, $time);
        end
        if (ev) begin
            n_cmp++;
            if (bus.out_data !== wd(mq[0], mlane)) begin
                n_bad++; $display("FAIL out_data: got %0d exp %0d t=%0t", bus.out_data, wd(mq[0], mlane), $time);
            end
        end
        n_cmp++;
        if (fifo_count !== 2'(mq.size())) begin
            n_bad++; $display("FAIL fifo_count: got %0d exp %0d t=%0t", fifo_count, mq.size(), $time);
        end
        n_cmp++;
        if (order_err !== merr || overflow !== movf) begin
            n_bad++; $display("FAIL flags: got err=%b ovf=%b exp err=%b ovf=%b t=%0t",
                              order_err, overflow, merr, movf, $time);
        end
        if (bus.out_valid === 1'b1 && rdy) got.push_back(bus.out_data);
        @(posedge clk);
        model_edge(vv, v, rdy, clr);
        #1;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic check_beats(input string name, input logic [L*W-1:0] a, input logic [L*W-1:0] b, input int nvec);
        n_cmp++;
        if (got.size() != nvec*L) begin
            n_bad++; $display("FAIL %s_count: got %0d beats exp %0d", name, got.size(), nvec*L);
        end else begin
            for (int i = 0; i < nvec*L; i++) begin
                logic [W-1:0] e;
                e = (i < L) ? wd(a, i) : wd(b, i-L);
                n_cmp++;
                if (got[i] !== e) begin
                    n_bad++; $display("FAIL %s_beat%0d: got %0d exp %0d", name, i, got[i], e);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b1, vec5(1, 2, 3, 4, 5), 1'b1, 1'b0);
        n_cmp++;
        if (bus.out_valid !== 1'b0 || fifo_count !== 2'd0 || order_err !== 1'b0 || overflow !== 1'b0) begin
            n_bad++; $display("FAIL reset_state: got v=%b cnt=%0d err=%b ovf=%b exp all 0",
                              bus.out_valid, fifo_count, order_err, overflow);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [L*W-1:0] v;
        v = vec5(900, 500, 300, 20, 7);
        got.delete();
        cycle(1'b1, v, 1'b1, 1'b0);
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin
            n_bad++; $display("FAIL single_latency: got out_valid=%b exp 1", bus.out_valid);
        end
        drain(8);
        check_beats("single", v, v, 1);
        n_cmp++;
        if (fifo_count !== 2'd0 || order_err !== 1'b0 || overflow !== 1'b0) begin
            n_bad++; $display("FAIL single_end: got cnt=%0d err=%b ovf=%b exp 0 0 0", fifo_count, order_err, overflow);
        end
    endtask

    task automatic test_stall();
        logic [L*W-1:0] v;
        v = vec5(900, 500, 300, 20, 7);
        got.delete();
        cycle(1'b1, v, 1'b0, 1'b0);
        for (int k = 0; k < 30; k++) cycle(1'b0, '0, (k % 3) == 0, 1'b0);
        check_beats("stall", v, v, 1);
    endtask

    task automatic test_order();
        logic [L*W-1:0] a, b;
        a = vec5(5, 5, 4, 4, 0);
        b = vec5(1, 9, 3, 2, 0);
        got.delete();
        cycle(1'b1, a, 1'b1, 1'b0);
        n_cmp++;
        if (order_err !== 1'b0) begin
            n_bad++; $display("FAIL order_clean: got %b exp 0", order_err);
        end
        cycle(1'b1, b, 1'b1, 1'b0);
        n_cmp++;
        if (order_err !== 1'b1) begin
            n_bad++; $display("FAIL order_set: got %b exp 1", order_err);
        end
        drain(12);
        check_beats("order", a, b, 2);
        cycle(1'b0, '0, 1'b1, 1'b1);
        n_cmp++;
        if (order_err !== 1'b0) begin
            n_bad++; $display("FAIL order_clr: got %b exp 0", order_err);
        end
    endtask

    task automatic test_overflow();
        logic [L*W-1:0] a, b, c;
        a = vec5(60, 50, 40, 30, 20);
        b = vec5(61, 51, 41, 31, 21);
        c = vec5(62, 52, 42, 32, 22);
        cycle(1'b1, a, 1'b0, 1'b0);
        cycle(1'b1, b, 1'b0, 1'b0);
        cycle(1'b1, c, 1'b0, 1'b0);
        n_cmp++;
        if (fifo_count !== 2'd2 || overflow !== 1'b1) begin
            n_bad++; $display("FAIL ovf_full: got cnt=%0d ovf=%b exp 2 1", fifo_count, overflow);
        end
        got.delete();
        drain(15);
        check_beats("ovf", a, b, 2);
        cycle(1'b0, '0, 1'b1, 1'b1);
    endtask

    task automatic test_full_pop();
        logic [L*W-1:0] a, b, c;
        a = vec5(70, 60, 50, 40, 30);
        b = vec5(71, 61, 51, 41, 31);
        c = vec5(72, 62, 52, 42, 32);
        cycle(1'b1, a, 1'b0, 1'b0);
        cycle(1'b1, b, 1'b0, 1'b0);
        for (int k = 0; k < 10 && mlane != L-1; k++) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, c, 1'b1, 1'b0);
        n_cmp++;
        if (fifo_count !== 2'd2 || overflow !== 1'b0) begin
            n_bad++; $display("FAIL full_pop: got cnt=%0d ovf=%b exp 2 0", fifo_count, overflow);
        end
        got.delete();
        drain(12);
        check_beats("full_pop", b, c, 2);
    endtask

    task automatic test_reset_mid();
        logic [L*W-1:0] a, b, d;
        a = vec5(10, 80, 30, 20, 10);
        b = vec5(99, 88, 77, 66, 55);
        d = vec5(400, 300, 200, 100, 0);
        cycle(1'b1, a, 1'b1, 1'b0);
        cycle(1'b1, b, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        rst_n = 1'b0;
        cycle(1'b0, '0, 1'b1, 1'b0);
        rst_n = 1'b1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || fifo_count !== 2'd0 || order_err !== 1'b0 || overflow !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid: got v=%b cnt=%0d err=%b ovf=%b exp all 0",
                              bus.out_valid, fifo_count, order_err, overflow);
        end
        cycle(1'b1, d, 1'b0, 1'b0);
        n_cmp++;
        if (bus.out_index !== 3'd0 || bus.out_data !== 16'd400) begin
            n_bad++; $display("FAIL rst_restart: got idx=%0d data=%0d exp 0 400", bus.out_index, bus.out_data);
        end
        drain(8);
    endtask

    task automatic test_random();
        logic [W-1:0]   q[$];
        logic [L*W-1:0] v;
        for (int k = 0; k < 600; k++) begin
            q.delete();
            for (int i = 0; i < L; i++) q.push_back(W'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) != 0) q.rsort();
            v = vec5(q[0], q[1], q[2], q[3], q[4]);
            cycle($urandom_range(0, 2) == 0, v, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
        end
        drain(12);
    endtask

    initial begin
        rst_n = 1'b0; vec_valid = 1'b0; vec_in = '0; clr_flags = 1'b0; bus.out_ready = 1'b0;
        mlane = 0; merr = 0; movf = 0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_stall();
        test_order();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sort_drain.md
Name: sort_drain

Overview:
- Receiving end of the 5-lane pipelined sorting network.
- Captures each parallel sorted vector the network presents, alongside a vec_valid strobe. vec_valid is the upstream valid delayed to match the network's 6-cycle latency.
- Buffers vectors in a small vector FIFO, because the network cannot be stalled.
- Streams the vector out one word per beat over a valid/ready interface, largest word first, and checks sort order on capture.

Parameters:
- WIDTH, 16, bits per word.
- LANES, 5, words per vector; lane 0 holds the largest word.
- DEPTH, 2, vector FIFO entries (power of two, at least 2).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- vec_valid  in  1  vec_in holds a network result this cycle.
- vec_in  in  LANES*WIDTH  sorted vector; lane i occupies bits [i*WIDTH +: WIDTH].
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the current beat.
- out_data  out  WIDTH  current word.
- out_index  out  $clog2(LANES)  lane number of the current word (0..LANES-1).
- out_last  out  1  current beat is lane LANES-1.
- fifo_count  out  $clog2(DEPTH+1)  number of vectors held.
- clr_flags  in  1  clears order_err and overflow.
- order_err  out  1  sticky: a captured vector was not non-increasing.
- overflow  out  1  sticky: a vector was dropped because the FIFO was full.

Behaviour:
- Reset values (rst_n low at an edge): FIFO pointers, fifo_count, lane counter, order_err and overflow all 0. Consequently out_valid=0, out_index=0, out_last=0. FIFO storage is not reset. out_data is don't-care while out_valid=0.
- Reset mid-stream discards all buffered vectors and the partial vector in flight. No further beats are emitted until a new push.
- Beat accepted ("fire") = out_valid & out_ready.
- Pop = fire & out_last.
- Push = vec_valid & (fifo_count<DEPTH | pop).
  - Full FIFO with a simultaneous pop accepts the push.
  - Drop = vec_valid & full & ~pop: vector discarded, overflow set the next cycle.
- fifo_count: +1 on push only, -1 on pop only, unchanged on both.
- Pointers wrap modulo DEPTH.
- Output timing:
  - out_valid = (fifo_count!=0). Decoded from registers only; no combinational path from vec_valid or out_ready to out_valid.
  - out_data = head vector lane[lane counter].
  - Latency: push at edge N gives out_valid=1 in cycle N+1, provided the FIFO was empty.
- Lane counter:
  - Increments on fire.
  - Wraps to 0 on fire at LANES-1, which is the pop.
  - Holds when out_ready=0.
  - out_data, out_index and out_last are held stable while out_valid & ~out_ready.
- Back-to-back vectors stream with no bubble: beat LANES-1 of vector k is followed directly by beat 0 of vector k+1.
- Order check, evaluated on each push: error if any lane[i] < lane[i+1] (unsigned). The vector is still stored and streamed; order_err is set the next cycle. Dropped vectors are not checked.
- Sticky flags:
  - clr_flags clears both flags next cycle.
  - A set event in the same cycle as clr_flags wins, so the flag ends up 1.
  - Reset overrides both.
- Throughput: sustained input of one vector per LANES cycles is lossless with out_ready=1. Faster input overflows once the DEPTH buffer is exhausted.

Decomposition:
- Package sort_pkg:
  - SORT_WIDTH=16, SORT_LANES=5, SORT_NET_LATENCY=6.
  - Typedef word_t [SORT_WIDTH-1:0].
  - Function lane_idx_w() = $clog2(SORT_LANES).
- Sub-module vec_fifo: parameterised DEPTH×(LANES*WIDTH) register FIFO with push/pop/count, no internal overflow policy.
- Serializer, order checker and flags live in sort_drain.

Test Plan:
- Reset then a single push of vec {900,500,300,20,7}, out_ready=1 -> out_valid rises the next cycle. Beats 900,500,300,20,7 with out_index 0..4 on consecutive cycles, out_last only on the 7 beat, fifo_count returns to 0, no flags set.
- Same vector with out_ready toggling 1,0,0,1,... -> words held during stalls. Exactly 5 fires in order, no duplicates or skips.
- Push {5,5,4,4,0} then {1,9,3,2,0} -> first vector clean. On the second, order_err=1 the cycle after its push, and both vectors are still streamed intact. Pulse clr_flags -> order_err=0.
- out_ready=0 and three pushes on consecutive cycles (DEPTH=2) -> fifo_count=2, third vector dropped, overflow=1. Release out_ready -> exactly 10 beats, from vectors 1 and 2 only.
- FIFO full, last beat firing in the same cycle as vec_valid -> push accepted, fifo_count stays 2, overflow stays 0.
- Assert rst_n=0 on beat 2 of a 5-beat vector with a second vector queued -> next cycle out_valid=0, fifo_count=0, flags 0. A subsequent push starts again at out_index 0.
